// File: rtl/adder_err_monitor_if.sv
// Sample stream from the approximate adder under test into the error monitor.
//   in_valid : sample present on op_a/op_b/s_apx (master -> slave)
//   in_ready : monitor accepts the sample this cycle (slave -> master)
//   op_a     : operand a fed to the adder, WIDTH bits
//   op_b     : operand b fed to the adder, WIDTH bits
//   s_apx    : sum produced by the approximate adder, WIDTH+1 bits
interface adder_err_monitor_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   s_apx;

  modport master (
    output in_valid,
    output op_a,
    output op_b,
    output s_apx,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  op_a,
    input  op_b,
    input  s_apx,
    output in_ready
  );

endinterface

// File: rtl/adder_err_monitor.sv
// Error-statistics monitor for a WIDTH-bit approximate adder. Each accepted sample
// (op_a, op_b, s_apx) is compared with the exact sum; the monitor accumulates the
// sample count, the count of erroneous samples, the saturating sum of error distances
// and the maximum error distance over a run of num_samples samples.
//
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   start        : one-cycle pulse, clears statistics and begins a run (IDLE/DONE only)
//   num_samples  : number of samples to accept in the run, latched on start
//   smp          : sample stream (valid/ready handshake), slave side
//   busy         : high while running or draining the pipeline
//   done         : one-cycle pulse when the statistics are final
//   sample_cnt   : samples retired into the statistics
//   err_cnt      : retired samples with nonzero error distance
//   ed_sum       : sum of error distances, saturating at all-ones
//   ed_max       : largest error distance seen
//   overflow     : sticky, ed_sum saturated during this run
module adder_err_monitor #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned SUM_W = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_samples,
  adder_err_monitor_if.slave   smp,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     sample_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [SUM_W-1:0]     ed_sum,
  output logic [WIDTH:0]       ed_max,
  output logic                 overflow
);

  localparam int unsigned SumX = SUM_W + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] accepted_q, accepted_d;
  logic             done_q, done_d;
  logic             clr_stats;

  // Stage 1: raw sample captured on accept.
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [WIDTH:0]   s1_s_q;

  // Stage 2: error distance of the stage-1 sample.
  logic             s2_valid_q;
  logic [WIDTH:0]   s2_ed_q;
  logic             s2_err_q;

  // Statistics.
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [SUM_W-1:0] ed_sum_q, ed_sum_d;
  logic [WIDTH:0]   ed_max_q, ed_max_d;
  logic             overflow_q, overflow_d;

  logic             in_ready_c;
  logic             accept;
  logic [WIDTH:0]   exact_c;
  logic [WIDTH:0]   ed_c;
  logic [SUM_W:0]   sum_ext_c;

  assign in_ready_c   = (state_q == StRun) && (accepted_q < target_q);
  assign accept       = smp.in_valid && in_ready_c;
  assign smp.in_ready = in_ready_c;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    accepted_d = accepted_q;
    done_d     = 1'b0;
    clr_stats  = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          target_d   = num_samples;
          accepted_d = '0;
          clr_stats  = 1'b1;
          if (num_samples == '0) begin
            // Re-entering DONE still pulses done, even from DONE itself.
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (accept) begin
          accepted_d = accepted_q + CNT_W'(1);
          if (accepted_q + CNT_W'(1) == target_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (!s1_valid_q && !s2_valid_q) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      target_q   <= '0;
      accepted_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      accepted_q <= accepted_d;
      done_q     <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: capture sample on handshake
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_s_q     <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_a_q <= smp.op_a;
        s1_b_q <= smp.op_b;
        s1_s_q <= smp.s_apx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: exact sum and absolute error distance (larger minus smaller)
  // ---------------------------------------------------------------------------
  always_comb begin
    exact_c = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    if (s1_s_q >= exact_c) begin
      ed_c = s1_s_q - exact_c;
    end else begin
      ed_c = exact_c - s1_s_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_ed_q    <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_ed_q  <= ed_c;
        s2_err_q <= (ed_c != '0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulators
  // ---------------------------------------------------------------------------
  always_comb begin
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    ed_sum_d     = ed_sum_q;
    ed_max_d     = ed_max_q;
    overflow_d   = overflow_q;
    // One extra bit catches the carry that signals saturation.
    sum_ext_c    = {1'b0, ed_sum_q} + SumX'(s2_ed_q);
    if (clr_stats) begin
      // Start is only honoured in IDLE/DONE, where the pipeline is empty.
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      ed_sum_d     = '0;
      ed_max_d     = '0;
      overflow_d   = 1'b0;
    end else if (s2_valid_q) begin
      sample_cnt_d = sample_cnt_q + CNT_W'(1);
      err_cnt_d    = err_cnt_q + CNT_W'(s2_err_q);
      if (sum_ext_c[SUM_W]) begin
        ed_sum_d   = '1;
        overflow_d = 1'b1;
      end else begin
        ed_sum_d = sum_ext_c[SUM_W-1:0];
      end
      if (s2_ed_q > ed_max_q) begin
        ed_max_d = s2_ed_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      ed_sum_q     <= '0;
      ed_max_q     <= '0;
      overflow_q   <= 1'b0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      ed_sum_q     <= ed_sum_d;
      ed_max_q     <= ed_max_d;
      overflow_q   <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy       = (state_q == StRun) || (state_q == StDrain);
  assign done       = done_q;
  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign ed_sum     = ed_sum_q;
  assign ed_max     = ed_max_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_adder_err_monitor.sv
// Directed bench for adder_err_monitor: a default build (SUM_W=48) and a reduced
// build (SUM_W=18) used to reach ed_sum saturation with a few samples.
module tb_adder_err_monitor;

  logic        clk;
  logic        rst_n;
  logic        start, start2;
  logic [31:0] num_samples, num_samples2;

  logic        busy, done, overflow;
  logic [31:0] sample_cnt, err_cnt;
  logic [47:0] ed_sum;
  logic [16:0] ed_max;

  logic        busy2, done2, overflow2;
  logic [31:0] sample_cnt2, err_cnt2;
  logic [17:0] ed_sum2;
  logic [16:0] ed_max2;

  int checks   = 0;
  int failures = 0;

  adder_err_monitor_if #(.WIDTH(16)) mif ();
  adder_err_monitor_if #(.WIDTH(16)) mif2 ();

  adder_err_monitor #(.WIDTH(16), .CNT_W(32), .SUM_W(48)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_samples (num_samples),
    .smp         (mif),
    .busy        (busy),
    .done        (done),
    .sample_cnt  (sample_cnt),
    .err_cnt     (err_cnt),
    .ed_sum      (ed_sum),
    .ed_max      (ed_max),
    .overflow    (overflow)
  );

  adder_err_monitor #(.WIDTH(16), .CNT_W(32), .SUM_W(18)) dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start2),
    .num_samples (num_samples2),
    .smp         (mif2),
    .busy        (busy2),
    .done        (done2),
    .sample_cnt  (sample_cnt2),
    .err_cnt     (err_cnt2),
    .ed_sum      (ed_sum2),
    .ed_max      (ed_max2),
    .overflow    (overflow2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] n);
    @(negedge clk);
    start = 1'b1;
    num_samples = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one sample and return on the negedge after it was accepted.
  task automatic feed(input logic [15:0] a, input logic [15:0] b, input logic [16:0] s);
    int w;
    mif.in_valid = 1'b1;
    mif.op_a = a;
    mif.op_b = b;
    mif.s_apx = s;
    w = 0;
    while (mif.in_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) check("feed_ready_timeout", {63'd0, mif.in_ready}, 64'd1);
    @(negedge clk);
    mif.in_valid = 1'b0;
  endtask

  task automatic feed2(input logic [15:0] a, input logic [15:0] b, input logic [16:0] s);
    int w;
    mif2.in_valid = 1'b1;
    mif2.op_a = a;
    mif2.op_b = b;
    mif2.s_apx = s;
    w = 0;
    while (mif2.in_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) check("feed2_ready_timeout", {63'd0, mif2.in_ready}, 64'd1);
    @(negedge clk);
    mif2.in_valid = 1'b0;
  endtask

  // Wait (bounded) for the done pulse, then confirm it lasts a single cycle.
  task automatic wait_done(input string tag);
    int w;
    w = 0;
    while (done !== 1'b1 && w < 30) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    @(negedge clk);
    check({tag, "_done_once"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    num_samples = '0;
    num_samples2 = '0;
    mif.in_valid = 1'b0;
    mif.op_a = '0;
    mif.op_b = '0;
    mif.s_apx = '0;
    mif2.in_valid = 1'b0;
    mif2.op_a = '0;
    mif2.op_b = '0;
    mif2.s_apx = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", {63'd0, mif.in_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_sample_cnt", {32'd0, sample_cnt}, 64'd0);
    check("rst_ed_sum", {16'd0, ed_sum}, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_in_ready", {63'd0, mif.in_ready}, 64'd0);

    // Exact sums: no error recorded
    do_start(32'd4);
    check("run_busy", {63'd0, busy}, 64'd1);
    feed(16'd1, 16'd2, 17'd3);
    feed(16'hFFFF, 16'hFFFF, 17'h1FFFE);
    feed(16'd0, 16'd0, 17'd0);
    feed(16'h8000, 16'h8000, 17'h10000);
    wait_done("exact");
    check("exact_sample_cnt", {32'd0, sample_cnt}, 64'd4);
    check("exact_err_cnt", {32'd0, err_cnt}, 64'd0);
    check("exact_ed_sum", {16'd0, ed_sum}, 64'd0);
    check("exact_ed_max", {47'd0, ed_max}, 64'd0);
    check("exact_busy", {63'd0, busy}, 64'd0);

    // Errors of both signs
    do_start(32'd3);
    check("err_cleared", {32'd0, sample_cnt}, 64'd0);
    feed(16'd5, 16'd5, 17'd8);
    feed(16'd5, 16'd5, 17'd12);
    feed(16'hFFFF, 16'd1, 17'h00000);
    wait_done("err");
    check("err_sample_cnt", {32'd0, sample_cnt}, 64'd3);
    check("err_err_cnt", {32'd0, err_cnt}, 64'd3);
    check("err_ed_sum", {16'd0, ed_sum}, 64'h10004);
    check("err_ed_max", {47'd0, ed_max}, 64'h10000);

    // Handshake and latency with in_valid held high, two-sample run
    do_start(32'd2);
    mif.op_a = 16'd0;
    mif.op_b = 16'd0;
    mif.s_apx = 17'd1;
    mif.in_valid = 1'b1;
    check("hs_ready_c0", {63'd0, mif.in_ready}, 64'd1);
    @(negedge clk);
    check("hs_ready_c1", {63'd0, mif.in_ready}, 64'd1);
    check("hs_cnt_c1", {32'd0, sample_cnt}, 64'd0);
    @(negedge clk);
    check("hs_ready_c2", {63'd0, mif.in_ready}, 64'd0);
    check("hs_busy_c2", {63'd0, busy}, 64'd1);
    check("hs_cnt_c2", {32'd0, sample_cnt}, 64'd0);
    @(negedge clk);
    check("hs_cnt_c3", {32'd0, sample_cnt}, 64'd1);
    @(negedge clk);
    check("hs_cnt_c4", {32'd0, sample_cnt}, 64'd2);
    check("hs_done_c4", {63'd0, done}, 64'd0);
    @(negedge clk);
    check("hs_done_c5", {63'd0, done}, 64'd1);
    check("hs_busy_c5", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("hs_done_c6", {63'd0, done}, 64'd0);
    check("hs_ready_c6", {63'd0, mif.in_ready}, 64'd0);
    check("hs_cnt_c6", {32'd0, sample_cnt}, 64'd2);
    check("hs_err_cnt", {32'd0, err_cnt}, 64'd2);
    check("hs_ed_sum", {16'd0, ed_sum}, 64'd2);
    check("hs_ed_max", {47'd0, ed_max}, 64'd1);
    mif.in_valid = 1'b0;

    // Zero-length run
    do_start(32'd0);
    check("zero_done", {63'd0, done}, 64'd1);
    check("zero_busy", {63'd0, busy}, 64'd0);
    check("zero_sample_cnt", {32'd0, sample_cnt}, 64'd0);
    check("zero_ed_sum", {16'd0, ed_sum}, 64'd0);
    @(negedge clk);
    check("zero_done_once", {63'd0, done}, 64'd0);

    // Start pulse mid-run is ignored
    do_start(32'd3);
    feed(16'd0, 16'd0, 17'd1);
    start = 1'b1;
    num_samples = 32'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("ign_sample_cnt", {32'd0, sample_cnt}, 64'd1);
    check("ign_ed_sum", {16'd0, ed_sum}, 64'd1);
    check("ign_busy", {63'd0, busy}, 64'd1);
    check("ign_ready", {63'd0, mif.in_ready}, 64'd1);
    feed(16'd0, 16'd0, 17'd2);
    feed(16'd0, 16'd0, 17'd3);
    wait_done("ign");
    check("ign_final_cnt", {32'd0, sample_cnt}, 64'd3);
    check("ign_final_sum", {16'd0, ed_sum}, 64'd6);
    check("ign_final_max", {47'd0, ed_max}, 64'd3);

    // Asynchronous reset mid-run
    do_start(32'd5);
    feed(16'd0, 16'd0, 17'd7);
    repeat (2) @(negedge clk);
    check("ar_pre_cnt", {32'd0, sample_cnt}, 64'd1);
    check("ar_pre_max", {47'd0, ed_max}, 64'd7);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_in_ready", {63'd0, mif.in_ready}, 64'd0);
    check("ar_busy", {63'd0, busy}, 64'd0);
    check("ar_sample_cnt", {32'd0, sample_cnt}, 64'd0);
    check("ar_ed_max", {47'd0, ed_max}, 64'd0);
    check("ar_ed_sum", {16'd0, ed_sum}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mif.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("ar_idle_ready", {63'd0, mif.in_ready}, 64'd0);
    check("ar_idle_busy", {63'd0, busy}, 64'd0);
    check("ar_idle_cnt", {32'd0, sample_cnt}, 64'd0);
    mif.in_valid = 1'b0;

    // Saturation on the SUM_W=18 build
    @(negedge clk);
    start2 = 1'b1;
    num_samples2 = 32'd3;
    @(negedge clk);
    start2 = 1'b0;
    feed2(16'd0, 16'd0, 17'h1FFFF);
    feed2(16'd0, 16'd0, 17'h1FFFE);
    repeat (2) @(negedge clk);
    check("sat_pre_sum", {46'd0, ed_sum2}, 64'h3FFFD);
    check("sat_pre_ovf", {63'd0, overflow2}, 64'd0);
    feed2(16'd0, 16'd0, 17'h1FFFF);
    w = 0;
    while (done2 !== 1'b1 && w < 30) begin
      @(negedge clk);
      w++;
    end
    check("sat_done", {63'd0, done2}, 64'd1);
    check("sat_ed_sum", {46'd0, ed_sum2}, 64'h3FFFF);
    check("sat_overflow", {63'd0, overflow2}, 64'd1);
    check("sat_ed_max", {47'd0, ed_max2}, 64'h1FFFF);
    check("sat_cnt", {32'd0, sample_cnt2}, 64'd3);
    check("sat_err_cnt", {32'd0, err_cnt2}, 64'd3);
    @(negedge clk);
    start2 = 1'b1;
    num_samples2 = 32'd0;
    @(negedge clk);
    start2 = 1'b0;
    check("sat_clr_ovf", {63'd0, overflow2}, 64'd0);
    check("sat_clr_sum", {46'd0, ed_sum2}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
